// File: rtl/bp_update_queue.sv
// In-order queue of resolved branch outcomes from both issue slots, drained one per cycle into the predictor's update port.
// Optional performance counters are built when BPU_PERF_CNT_EN is defined.
module bp_update_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallE,
  input  logic            branch1E,
  input  logic            branch2E,
  input  logic [PC_W-1:0] pcE,
  input  logic [PC_W-1:0] PcPlus4E,
  input  logic            actual_take1E,
  input  logic            actual_take2E,
  input  logic            pred_take1E,
  input  logic            pred_take2E,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [PC_W-1:0] upd_pc,
  output logic            upd_take,
  output logic            queue_full,
  output logic            drop_flag,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef logic [PC_W:0] entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            drop_q, drop_d;

  logic            deq;
  logic            req1, req2;
  logic [1:0]      n_req, n_enq;
  logic [CW-1:0]   free;
  logic            drop;
  entry_t          first_entry, second_entry;

  always_comb begin
    deq   = (count_q != '0) & upd_ready;
    req1  = branch1E & ~stallE;
    req2  = branch2E & ~stallE;
    n_req = {1'b0, req1} + {1'b0, req2};
    // A slot released by this cycle's dequeue is reusable for this cycle's enqueue.
    free  = DEPTH_C - count_q + CW'(deq);

    drop = (CW'(n_req) > free);
    if (!drop)              n_enq = n_req;
    else if (free != '0)    n_enq = 2'd1;
    else                    n_enq = 2'd0;

    // The oldest requesting slot always takes the first free position.
    first_entry  = req1 ? {pcE, actual_take1E} : {PcPlus4E, actual_take2E};
    second_entry = {PcPlus4E, actual_take2E};

    mem_d = mem_q;
    if (n_enq != 2'd0) mem_d[wr_ptr_q] = first_entry;
    if (n_enq == 2'd2) mem_d[wr_ptr_q + AW'(1)] = second_entry;

    wr_ptr_d = wr_ptr_q + AW'(n_enq);
    rd_ptr_d = rd_ptr_q + AW'(deq);
    count_d  = count_q + CW'(n_enq) - CW'(deq);
    drop_d   = drop_q | drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign upd_valid             = (count_q != '0);
  assign {upd_pc, upd_take}    = mem_q[rd_ptr_q];
  assign queue_full            = (count_q >= DEPTH_C - CW'(1));
  assign drop_flag             = drop_q;

`ifdef BPU_PERF_CNT_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;
  logic        mis1, mis2;

  always_comb begin
    mis1          = req1 & (actual_take1E != pred_take1E);
    mis2          = req2 & (actual_take2E != pred_take2E);
    branch_cnt_d  = branch_cnt_q + 32'(n_req);
    mispred_cnt_d = mispred_cnt_q + 32'(mis1) + 32'(mis2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  logic unused_pred;
  assign unused_pred = ^{pred_take1E, pred_take2E};
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: doc/bp_update_queue.md
# bp_update_queue

Writer-side companion to the two-way BHT/PHT branch predictor. It sits at the end of the execute stage and captures resolved branch outcomes from both issue slots, up to two per cycle. It buffers them in order in a small FIFO and drains them one per cycle into the predictor's single update port over a valid/ready handshake. This removes the current "slot 1 wins, slot 2 lost" update collision.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥4
- PC_W, 32, width of stored branch PC

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-low
- stallE  in  1  execute stage stalled; no enqueue while high
- branch1E  in  1  slot-1 instruction in E is a conditional branch
- branch2E  in  1  slot-2 instruction in E is a conditional branch
- pcE  in  PC_W  slot-1 PC
- PcPlus4E  in  PC_W  slot-2 PC
- actual_take1E  in  1  slot-1 resolved direction
- actual_take2E  in  1  slot-2 resolved direction
- pred_take1E  in  1  slot-1 predicted direction (statistics only)
- pred_take2E  in  1  slot-2 predicted direction (statistics only)
- upd_valid  out  1  head entry valid
- upd_ready  in  1  predictor accepts head this cycle
- upd_pc  out  PC_W  head entry PC
- upd_take  out  1  head entry resolved direction
- queue_full  out  1  fewer than 2 free entries; used as a stall request
- drop_flag  out  1  sticky; an outcome was dropped for lack of space
- branch_cnt, mispred_cnt  out  32 each  performance counters (see Configuration)

## Operation
- Enqueue request: n_req = branch1E + branch2E, gated by ~stallE. Slot 1 is written before slot 2, so age order is preserved.
- Dequeue: occurs when upd_valid & upd_ready; the head advances by one.
- Storage: mem[DEPTH] of {pc, take}.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Free space is evaluated as free = DEPTH − count + deq, so a same-cycle dequeue frees a slot for enqueue.
- Insufficient space:
  - If n_req exceeds free, slot 1 is enqueued if one slot is free and slot 2 is dropped.
  - If no slot is free, both outcomes are dropped.
  - Every drop sets drop_flag, which is cleared only by reset.
- upd_valid = (count != 0). upd_pc and upd_take read mem[rd_ptr] directly from registers, with no output mux on enqueue data.
- queue_full = (count ≥ DEPTH−1), computed from registered count.
- Reset values (rst low at a clk edge):
  - wr_ptr, rd_ptr, count = 0
  - upd_valid = 0
  - drop_flag = 0
  - counters = 0
  - mem contents don't care; upd_pc and upd_take are unspecified while upd_valid = 0.

## Timing
- Latency: an outcome enqueued at edge N appears on upd_valid/upd_pc at cycle N+1 if the FIFO was empty. There is no same-cycle bypass.
- Throughput: 2 in, 1 out per cycle.
- Simultaneous enqueue and dequeue:
  - count_next = count + n_enq − deq.
  - With count = DEPTH−1, deq = 1 and n_req = 2, both slots enqueue and count becomes DEPTH.
- Full at DEPTH with no dequeue: all requests are dropped.
- Empty with enqueue in the same cycle: no dequeue that cycle, since upd_valid is registered-based.
- upd_ready is sampled only when upd_valid = 1. Head fields are stable while upd_valid & ~upd_ready.
- Reset mid-operation: all queued entries are discarded and upd_valid is 0 on the next cycle.
- stallE = 1: no enqueue, which prevents duplicate capture of a stalled E instruction. Dequeue continues.

## Configuration
- BPU_PERF_CNT_EN defined:
  - branch_cnt increments by the number of valid branches per unstalled cycle (0/1/2).
  - mispred_cnt increments by the count of slots where branchXE & (actual_takeXE ≠ pred_takeXE), same gating.
  - Counters include dropped outcomes and wrap at 2^32.
- BPU_PERF_CNT_EN undefined: no counter registers; branch_cnt and mispred_cnt tie to 0.

## Test plan
- Reset, then branch1E = branch2E = 1 with pcE = 0x100, PcPlus4E = 0x104, takes 1/0, upd_ready = 1 → cycle+1 upd_pc = 0x100, take = 1; cycle+2 upd_pc = 0x104, take = 0; then upd_valid = 0.
- Hold upd_ready = 0 and inject dual branches for 4 cycles (DEPTH = 8) → count = 8, queue_full = 1 from count = 7, drop_flag = 0. A 5th dual request → drop_flag = 1, count stays 8.
- count = 7, upd_ready = 1, dual request → both enqueued, count = 8, no drop. Draining 8 cycles returns PCs in exact arrival order across pointer wrap.
- stallE = 1 with branch1E = 1 for 3 cycles → no enqueue, upd_valid stays 0. Branch_cnt is unchanged with BPU_PERF_CNT_EN.
- BPU_PERF_CNT_EN: 10 dual branches, 3 slots with pred ≠ actual → branch_cnt = 20, mispred_cnt = 3.
- Assert rst low while 5 entries are queued → next cycle upd_valid = 0, drop_flag = 0, counters = 0. A new enqueue appears after 1 cycle.
